// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver state encodings and divider helpers.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_DONE   = 3'd5
    } rx_state_t;

    function automatic int f_tick_div(input int clk_freq, input int baud, input int os);
        return int'(longint'(clk_freq) / (longint'(baud) * longint'(os)));
    endfunction

    function automatic int f_cnt_width(input int n_states);
        return (n_states > 1) ? $clog2(n_states) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle pulse every p_DIV clocks, phase reset by restart.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int p_DIV = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_restart,
    output logic o_tick
);

    localparam int lp_W = f_cnt_width(p_DIV);
    localparam logic [lp_W-1:0] lp_LAST = lp_W'(p_DIV - 1);

    logic [lp_W-1:0] cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_restart) begin
            cnt <= '0;
        end else if (cnt == lp_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign o_tick = (cnt == lp_LAST);

endmodule

// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver with 3-sample majority vote, parity, framing and break detection.
//  state     | meaning
//  RX_IDLE   | waiting for a synchronised falling edge while enabled
//  RX_START  | start bit; majority 1 at decision is a false start
//  RX_DATA   | shifting data bits, LSB first
//  RX_PARITY | capturing the parity bit (only when parity enabled)
//  RX_STOP   | checking stop bits; leaves right after the last stop decision
//  RX_DONE   | one-cycle valid pulse, then back to idle
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int p_CLK_FREQ   = 12_000_000,
    parameter int p_BAUDRATE   = 9600,
    parameter int p_OVERSAMPLE = 16,
    parameter int p_DATA_BITS  = 8,
    parameter int p_PARITY     = 0,
    parameter int p_STOP_BITS  = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_en,
    input  logic                   i_uart_rx,
    output logic                   o_valid,
    output logic [p_DATA_BITS-1:0] o_data,
    output logic                   o_parity_err,
    output logic                   o_frame_err,
    output logic                   o_break,
    output logic                   o_busy
);

    localparam int lp_TICK_DIV = f_tick_div(p_CLK_FREQ, p_BAUDRATE, p_OVERSAMPLE);
    localparam int lp_SW = f_cnt_width(p_OVERSAMPLE);
    localparam int lp_DW = f_cnt_width(p_DATA_BITS);
    localparam int lp_PW = f_cnt_width(p_STOP_BITS);

    // Sample counter holds the index before the tick, so compares are one below the target index.
    localparam logic [lp_SW-1:0] lp_IDX_EARLY  = lp_SW'(p_OVERSAMPLE/2 - 2);
    localparam logic [lp_SW-1:0] lp_IDX_MID    = lp_SW'(p_OVERSAMPLE/2 - 1);
    localparam logic [lp_SW-1:0] lp_IDX_DECIDE = lp_SW'(p_OVERSAMPLE/2);
    localparam logic [lp_SW-1:0] lp_IDX_LAST   = lp_SW'(p_OVERSAMPLE - 1);
    localparam logic [lp_DW-1:0] lp_DATA_LAST  = lp_DW'(p_DATA_BITS - 1);
    localparam logic [lp_PW-1:0] lp_STOP_LAST  = lp_PW'(p_STOP_BITS - 1);

    if (lp_TICK_DIV < 2) begin : g_div_check
        $error("uart_rx_cfg: clock too slow for baud rate and oversampling (tick divider < 2)");
    end

    rx_state_t state, state_next;

    logic rx_meta, rx_sync, rx_prev;
    logic tick, restart, decide, bit_val, start_edge, frame_end, parity_err;
    logic hist_early, hist_mid;
    logic stop_err, seen_one, parity_bit;
    logic [lp_SW-1:0] sample_cnt;
    logic [lp_DW-1:0] bit_cnt;
    logic [lp_PW-1:0] stop_cnt;
    logic [p_DATA_BITS-1:0] shift_reg;

    uart_baud_tick #(
        .p_DIV(lp_TICK_DIV)
    ) u_tick (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_restart(restart),
        .o_tick   (tick)
    );

    assign start_edge = rx_prev & ~rx_sync & i_en;
    assign restart    = (state == RX_IDLE) && start_edge;
    assign decide     = tick && (sample_cnt == lp_IDX_DECIDE);
    assign bit_val    = (hist_early & hist_mid) | (hist_early & rx_sync) | (hist_mid & rx_sync);
    assign frame_end  = decide && (state == RX_STOP) && (stop_cnt == lp_STOP_LAST);

    always_comb begin
        parity_err = 1'b0;
        if (p_PARITY == PARITY_ODD) begin
            parity_err = ~((^shift_reg) ^ parity_bit);
        end else if (p_PARITY == PARITY_EVEN) begin
            parity_err = (^shift_reg) ^ parity_bit;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= RX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RX_IDLE:   if (start_edge) state_next = RX_START;
            RX_START:  if (decide) state_next = bit_val ? RX_IDLE : RX_DATA;
            RX_DATA: begin
                if (decide && bit_cnt == lp_DATA_LAST) begin
                    state_next = (p_PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
                end
            end
            RX_PARITY: if (decide) state_next = RX_STOP;
            RX_STOP:   if (frame_end) state_next = RX_DONE;
            RX_DONE:   state_next = RX_IDLE;
            default:   state_next = RX_IDLE;
        endcase
    end

    always_comb begin
        o_valid = (state == RX_DONE);
        o_busy  = (state != RX_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta      <= 1'b1;
            rx_sync      <= 1'b1;
            rx_prev      <= 1'b1;
            hist_early   <= 1'b1;
            hist_mid     <= 1'b1;
            sample_cnt   <= '0;
            bit_cnt      <= '0;
            stop_cnt     <= '0;
            shift_reg    <= '0;
            parity_bit   <= 1'b0;
            stop_err     <= 1'b0;
            seen_one     <= 1'b0;
            o_data       <= '0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_break      <= 1'b0;
        end else begin
            rx_meta <= i_uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;

            if (restart) begin
                sample_cnt <= '0;
            end else if (tick) begin
                sample_cnt <= (sample_cnt == lp_IDX_LAST) ? '0 : sample_cnt + 1'b1;
            end

            if (tick && sample_cnt == lp_IDX_EARLY) hist_early <= rx_sync;
            if (tick && sample_cnt == lp_IDX_MID)   hist_mid   <= rx_sync;

            if (restart) begin
                bit_cnt    <= '0;
                stop_cnt   <= '0;
                parity_bit <= 1'b0;
                stop_err   <= 1'b0;
                seen_one   <= 1'b0;
            end else if (decide) begin
                case (state)
                    RX_DATA: begin
                        shift_reg <= {bit_val, shift_reg[p_DATA_BITS-1:1]};
                        seen_one  <= seen_one | bit_val;
                        if (bit_cnt != lp_DATA_LAST) bit_cnt <= bit_cnt + 1'b1;
                    end
                    RX_PARITY: begin
                        parity_bit <= bit_val;
                        seen_one   <= seen_one | bit_val;
                    end
                    RX_STOP: begin
                        stop_err <= stop_err | ~bit_val;
                        seen_one <= seen_one | bit_val;
                        if (stop_cnt != lp_STOP_LAST) stop_cnt <= stop_cnt + 1'b1;
                    end
                    default: begin
                    end
                endcase
            end

            // Final stop bit is folded in directly since its register update lands on this same edge.
            if (frame_end) begin
                o_data       <= shift_reg;
                o_parity_err <= parity_err;
                o_frame_err  <= stop_err | ~bit_val;
                o_break      <= ~(seen_one | bit_val);
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three instances (8N1, 8E1, 8N2) at 32 clocks per bit.
module tb_uart_rx_cfg;

    typedef struct {
        int         ch;
        logic [15:0] bits;
        int         n;
        int         gbit;
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
        int         lat;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic [2:0] rx  = 3'b111;
    logic [2:0] valid, busy, perr, ferr, brk;
    logic [7:0] data [3];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int vcnt [3] = '{0, 0, 0};
    int lat [3] = '{0, 0, 0};
    int start_cyc [3] = '{0, 0, 0};
    vec_t vecs [12];
    vec_t tmp;
    int base;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (valid[i]) begin
                vcnt[i] <= vcnt[i] + 1;
                lat[i]  <= cyc - start_cyc[i];
            end
        end
    end

    uart_rx_cfg #(.p_CLK_FREQ(3_200_000), .p_BAUDRATE(100_000), .p_OVERSAMPLE(16),
                  .p_DATA_BITS(8), .p_PARITY(0), .p_STOP_BITS(1)) u_8n1 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_uart_rx(rx[0]), .o_valid(valid[0]),
        .o_data(data[0]), .o_parity_err(perr[0]), .o_frame_err(ferr[0]),
        .o_break(brk[0]), .o_busy(busy[0]));

    uart_rx_cfg #(.p_CLK_FREQ(3_200_000), .p_BAUDRATE(100_000), .p_OVERSAMPLE(16),
                  .p_DATA_BITS(8), .p_PARITY(2), .p_STOP_BITS(1)) u_8e1 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_uart_rx(rx[1]), .o_valid(valid[1]),
        .o_data(data[1]), .o_parity_err(perr[1]), .o_frame_err(ferr[1]),
        .o_break(brk[1]), .o_busy(busy[1]));

    uart_rx_cfg #(.p_CLK_FREQ(3_200_000), .p_BAUDRATE(100_000), .p_OVERSAMPLE(16),
                  .p_DATA_BITS(8), .p_PARITY(0), .p_STOP_BITS(2)) u_8n2 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_uart_rx(rx[2]), .o_valid(valid[2]),
        .o_data(data[2]), .o_parity_err(perr[2]), .o_frame_err(ferr[2]),
        .o_break(brk[2]), .o_busy(busy[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // bits[0] is the start bit; each bit is held 32 clocks, gbit gets a 1-clock flip at its centre.
    task automatic send_frame(input int ch, input logic [15:0] bits, input int n, input int gbit,
                              input int abort_bit, input int en_off_bit);
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < 32; c++) begin
                @(negedge clk);
                if (b == 0 && c == 0) start_cyc[ch] = cyc;
                if (b == en_off_bit && c == 0) en = 1'b0;
                if (b == abort_bit && c == 16) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    rx[ch] = 1'b1;
                    return;
                end
                rx[ch] = (b == gbit && c == 16) ? ~bits[b] : bits[b];
            end
        end
        @(negedge clk);
        rx[ch] = 1'b1;
    endtask

    task automatic run_vec(input string tag, input vec_t v, input int en_off_bit);
        int b0;
        b0 = vcnt[v.ch];
        send_frame(v.ch, v.bits, v.n, v.gbit, -1, en_off_bit);
        repeat (64) @(negedge clk);
        chk({tag, "_valid_count"}, vcnt[v.ch] - b0, 1);
        chk({tag, "_data"}, data[v.ch], v.data);
        chk({tag, "_parity_err"}, perr[v.ch], v.perr);
        chk({tag, "_frame_err"}, ferr[v.ch], v.ferr);
        chk({tag, "_break"}, brk[v.ch], v.brk);
        chk({tag, "_busy_after"}, busy[v.ch], 1'b0);
        chk({tag, "_latency"}, lat[v.ch], v.lat);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{0, 16'h034A, 10, -1, 8'hA5, 1'b0, 1'b0, 1'b0, 309};
        vecs[1]  = '{0, 16'h0200, 10, -1, 8'h00, 1'b0, 1'b0, 1'b0, 309};
        vecs[2]  = '{0, 16'h03FE, 10, -1, 8'hFF, 1'b0, 1'b0, 1'b0, 309};
        vecs[3]  = '{0, 16'h014A, 10, -1, 8'hA5, 1'b0, 1'b1, 1'b0, 309};
        vecs[4]  = '{0, 16'h034A, 10,  2, 8'hA5, 1'b0, 1'b0, 1'b0, 309};
        vecs[5]  = '{1, 16'h0606, 11, -1, 8'h03, 1'b1, 1'b0, 1'b0, 341};
        vecs[6]  = '{1, 16'h0406, 11, -1, 8'h03, 1'b0, 1'b0, 1'b0, 341};
        vecs[7]  = '{1, 16'h04AA, 11, -1, 8'h55, 1'b0, 1'b0, 1'b0, 341};
        vecs[8]  = '{1, 16'h0402, 11, -1, 8'h01, 1'b1, 1'b0, 1'b0, 341};
        vecs[9]  = '{2, 16'h02B4, 11, -1, 8'h5A, 1'b0, 1'b1, 1'b0, 341};
        vecs[10] = '{2, 16'h0786, 11, -1, 8'hC3, 1'b0, 1'b0, 1'b0, 341};
        vecs[11] = '{1, 16'h0006, 11, -1, 8'h03, 1'b0, 1'b1, 1'b0, 341};

        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_valid%0d", i), valid[i], 1'b0);
            chk($sformatf("reset_busy%0d", i), busy[i], 1'b0);
            chk($sformatf("reset_data%0d", i), data[i], 8'h00);
            chk($sformatf("reset_flags%0d", i), {perr[i], ferr[i], brk[i]}, 3'b000);
        end
        rst = 1'b0;
        repeat (8) @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i], -1);
        end

        // Short low glitch: start is detected, then rejected at the start-bit decision.
        base = vcnt[0];
        @(negedge clk);
        rx[0] = 1'b0;
        repeat (6) @(negedge clk);
        rx[0] = 1'b1;
        chk("glitch_busy_rises", busy[0], 1'b1);
        repeat (32) @(negedge clk);
        chk("glitch_busy_falls", busy[0], 1'b0);
        chk("glitch_no_valid", vcnt[0] - base, 0);

        // Break: line low for 15 bit times.
        base = vcnt[0];
        @(negedge clk);
        rx[0] = 1'b0;
        start_cyc[0] = cyc;
        repeat (480) @(negedge clk);
        rx[0] = 1'b1;
        repeat (64) @(negedge clk);
        chk("break_valid_count", vcnt[0] - base, 1);
        chk("break_data", data[0], 8'h00);
        chk("break_flag", brk[0], 1'b1);
        chk("break_frame_err", ferr[0], 1'b1);
        chk("break_parity_err", perr[0], 1'b0);
        chk("break_latency", lat[0], 309);
        chk("break_busy_after", busy[0], 1'b0);
        tmp = '{0, 16'h0278, 10, -1, 8'h3C, 1'b0, 1'b0, 1'b0, 309};
        run_vec("after_break", tmp, -1);

        // Reset in the middle of data bit 4 of a 0x96 frame.
        base = vcnt[0];
        send_frame(0, 16'h032C, 10, -1, 5, -1);
        chk("abort_busy", busy[0], 1'b0);
        chk("abort_valid", valid[0], 1'b0);
        chk("abort_data_cleared", data[0], 8'h00);
        chk("abort_flags_cleared", {perr[0], ferr[0], brk[0]}, 3'b000);
        repeat (64) @(negedge clk);
        chk("abort_no_valid", vcnt[0] - base, 0);
        run_vec("after_rst", tmp, -1);

        // Disabled at the start edge: whole frame ignored.
        base = vcnt[0];
        en = 1'b0;
        send_frame(0, 16'h0302, 10, -1, -1, -1);
        repeat (64) @(negedge clk);
        en = 1'b1;
        chk("en_off_no_valid", vcnt[0] - base, 0);
        chk("en_off_busy", busy[0], 1'b0);

        // Enable dropped after the frame started: frame still reported.
        tmp = '{0, 16'h02B4, 10, -1, 8'h5A, 1'b0, 1'b0, 1'b0, 309};
        run_vec("en_drop", tmp, 3);
        en = 1'b1;
        repeat (8) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
